// File: rtl/wb_timer_multi_if.sv
// Wishbone slave bundle for the multi-channel timer. Signal names keep the
// slave-side _i/_o suffixes so both ends read the same as the bus spec.
interface wb_timer_multi_if;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_i;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_we_i;
  logic        wb_ack_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_stb_i, wb_cyc_i, wb_we_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_stb_i, wb_cyc_i, wb_we_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/wb_timer_multi.sv
// CHANNELS up-counters on a shared prescaler, with compare, one-shot/auto-reload,
// cascade from the previous channel, and masked W1C interrupt status.

module wb_timer_chan #(
  parameter int WIDTH    = 32,
  parameter bit HAS_CASC = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_tick,
  input  logic             i_prev_match,
  input  logic             i_ctrl_we,
  input  logic [2:0]       i_ctrl_wd,
  input  logic             i_cmp_we,
  input  logic [WIDTH-1:0] i_cmp_wd,
  input  logic             i_cnt_we,
  input  logic [WIDTH-1:0] i_cnt_wd,
  output logic [2:0]       o_ctrl,
  output logic [WIDTH-1:0] o_cmp,
  output logic [WIDTH-1:0] o_cnt,
  output logic             o_match
);
  logic             r_en, r_ar, r_casc;
  logic [WIDTH-1:0] r_cmp, r_cnt;
  logic             w_step;

  // Match is combinational so a cascaded channel steps in the same cycle.
  assign w_step  = r_casc ? i_prev_match : i_tick;
  assign o_match = r_en & w_step & (r_cnt == r_cmp);
  assign o_ctrl  = {r_casc, r_ar, r_en};
  assign o_cmp   = r_cmp;
  assign o_cnt   = r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_en   <= 1'b0;
      r_ar   <= 1'b0;
      r_casc <= 1'b0;
      r_cmp  <= '0;
      r_cnt  <= '0;
    end else begin
      if (i_ctrl_we) begin
        r_en   <= i_ctrl_wd[0];
        r_ar   <= i_ctrl_wd[1];
        r_casc <= i_ctrl_wd[2] & HAS_CASC;
      end else if (o_match && !r_ar) begin
        r_en <= 1'b0;
      end
      if (i_cmp_we) r_cmp <= i_cmp_wd;
      if (i_cnt_we)
        r_cnt <= i_cnt_wd;
      else if (r_en && w_step)
        r_cnt <= o_match ? '0 : r_cnt + WIDTH'(1);
    end
  end
endmodule

module wb_timer_multi #(
  parameter int CHANNELS       = 2,
  parameter int WIDTH          = 32,
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic                clk,
  input  logic                reset,
  wb_timer_multi_if.slave     wb,
  output logic [CHANNELS-1:0] intr,
  output logic                intr_any
);
  logic                           r_ack;
  logic [31:0]                    r_dat;
  logic [PRESCALE_WIDTH-1:0]      r_pre, r_pcnt;
  logic [CHANNELS-1:0]            r_status, r_mask, r_intr;

  logic                           w_acc, w_wr, w_glob, w_tick;
  logic                           w_pre_we, w_st_we, w_mask_we;
  logic [5:0]                     w_word;
  logic [2:0]                     w_ch;
  logic [1:0]                     w_reg;
  logic [31:0]                    w_bmask, w_rdata;
  logic [CHANNELS-1:0]            w_match, w_clr;
  logic [CHANNELS-1:0][2:0]       w_ctrl;
  logic [CHANNELS-1:0][WIDTH-1:0] w_cmp, w_cnt;
  logic                           w_unused;

  function automatic logic [31:0] f_merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [31:0] bm);
    return (old & ~bm) | (wd & bm);
  endfunction

  // An access is taken only while ack is low, which spaces acks two cycles apart.
  assign w_acc    = wb.wb_cyc_i & wb.wb_stb_i & ~r_ack;
  assign w_wr     = w_acc & wb.wb_we_i;
  assign w_word   = wb.wb_adr_i[7:2];
  assign w_glob   = w_word[5];
  assign w_ch     = w_word[4:2];
  assign w_reg    = w_word[1:0];
  assign w_bmask  = {{8{wb.wb_sel_i[3]}}, {8{wb.wb_sel_i[2]}},
                     {8{wb.wb_sel_i[1]}}, {8{wb.wb_sel_i[0]}}};
  assign w_unused = ^{wb.wb_adr_i[31:8], wb.wb_adr_i[1:0]};

  assign w_pre_we  = w_wr & w_glob & (w_word[4:0] == 5'd0);
  assign w_st_we   = w_wr & w_glob & (w_word[4:0] == 5'd1);
  assign w_mask_we = w_wr & w_glob & (w_word[4:0] == 5'd2);
  assign w_clr     = w_st_we ? CHANNELS'(wb.wb_dat_i & w_bmask) : '0;
  assign w_tick    = (r_pcnt == r_pre);

  assign wb.wb_ack_o = r_ack;
  assign wb.wb_dat_o = r_dat;
  assign intr        = r_intr;
  assign intr_any    = |r_intr;

  for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
    logic             w_sel, w_prev, w_m;
    logic [2:0]       w_ctl_wd;
    logic [WIDTH-1:0] w_cmp_wd, w_cnt_wd;

    assign w_sel = w_wr & ~w_glob & (w_ch == 3'(n));
    if (n == 0) begin : g_head
      assign w_prev = 1'b0;
    end else begin : g_link
      assign w_prev = g_ch[n-1].w_m;
    end
    assign w_ctl_wd = 3'(f_merge(32'(w_ctrl[n]), wb.wb_dat_i, w_bmask));
    assign w_cmp_wd = WIDTH'(f_merge(32'(w_cmp[n]), wb.wb_dat_i, w_bmask));
    assign w_cnt_wd = WIDTH'(f_merge(32'(w_cnt[n]), wb.wb_dat_i, w_bmask));

    wb_timer_chan #(.WIDTH(WIDTH), .HAS_CASC(n != 0)) u_chan (
      .clk          (clk),
      .reset        (reset),
      .i_tick       (w_tick),
      .i_prev_match (w_prev),
      .i_ctrl_we    (w_sel & (w_reg == 2'd0)),
      .i_ctrl_wd    (w_ctl_wd),
      .i_cmp_we     (w_sel & (w_reg == 2'd1)),
      .i_cmp_wd     (w_cmp_wd),
      .i_cnt_we     (w_sel & (w_reg == 2'd2)),
      .i_cnt_wd     (w_cnt_wd),
      .o_ctrl       (w_ctrl[n]),
      .o_cmp        (w_cmp[n]),
      .o_cnt        (w_cnt[n]),
      .o_match      (w_m)
    );
    assign w_match[n] = w_m;
  end

  always_comb begin
    w_rdata = '0;
    if (w_glob) begin
      case (w_word[4:0])
        5'd0:    w_rdata = 32'(r_pre);
        5'd1:    w_rdata = 32'(r_status);
        5'd2:    w_rdata = 32'(r_mask);
        default: ;
      endcase
    end else begin
      for (int n = 0; n < CHANNELS; n++) begin
        if (w_ch == 3'(n)) begin
          case (w_reg)
            2'd0:    w_rdata = 32'(w_ctrl[n]);
            2'd1:    w_rdata = 32'(w_cmp[n]);
            2'd2:    w_rdata = 32'(w_cnt[n]);
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ack <= 1'b0;
      r_dat <= '0;
    end else begin
      r_ack <= w_acc;
      r_dat <= (w_acc && !wb.wb_we_i) ? w_rdata : '0;
    end
  end

  // Writing PRESCALE restarts the count so the first tick is a full period away.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pre  <= '0;
      r_pcnt <= '0;
    end else if (w_pre_we) begin
      r_pre  <= PRESCALE_WIDTH'(f_merge(32'(r_pre), wb.wb_dat_i, w_bmask));
      r_pcnt <= '0;
    end else begin
      r_pcnt <= w_tick ? '0 : r_pcnt + PRESCALE_WIDTH'(1);
    end
  end

  // Hardware set is OR-ed after the clear so it wins a same-cycle W1C.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_status <= '0;
      r_mask   <= '0;
      r_intr   <= '0;
    end else begin
      r_status <= (r_status & ~w_clr) | w_match;
      if (w_mask_we) r_mask <= CHANNELS'(f_merge(32'(r_mask), wb.wb_dat_i, w_bmask));
      r_intr <= r_status & r_mask;
    end
  end
endmodule
